rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: register data width.
REQ-002 The block SHALL have parameter AddrWidth, default 5: register address width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4: consecutive B-blocked cycles before B is forced.
REQ-004 The block SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 The block SHALL have ports a_valid (in, 1), a_addr (in, AddrWidth), a_data (in, WIDTH) and a_ready (out, 1): requester A, the pipeline writeback.
REQ-007 The block SHALL have ports b_valid (in, 1), b_addr (in, AddrWidth), b_data (in, WIDTH) and b_ready (out, 1): requester B, the multi-cycle load/MIO unit.
REQ-008 The block SHALL have ports rf_we (out, 1), rf_waddr (out, AddrWidth) and rf_wdata (out, WIDTH): registered drive of the register-file write port.
REQ-009 The block SHALL have port rf_src_b, output, 1: registered; 1 when the current rf_we write came from B.
REQ-010 The block SHALL have port conflict_cnt, output, 16: saturating count of cycles where both requesters were valid.

Function
REQ-011 The block SHALL form a transfer on a requester when its valid and ready are both 1 in the same cycle.
REQ-012 The block SHALL derive a_ready and b_ready combinationally from the valids and state; at most one ready SHALL be 1 per cycle.
REQ-013 In state A_PRIO, the block SHALL set a_ready=a_valid and set b_ready=b_valid and not a_valid.
REQ-014 In state B_FORCED, the block SHALL set b_ready=b_valid and a_ready=0.
REQ-015 The block SHALL hold wait_cnt, counting cycles with b_valid=1 and b_ready=0; wait_cnt SHALL clear on any B transfer or when b_valid=0.
REQ-016 A_PRIO SHALL move to B_FORCED when b_valid=1, b_ready=0 and wait_cnt==STARVE_LIMIT-1.
REQ-017 B_FORCED SHALL return to A_PRIO on a B transfer, or when b_valid drops to 0; it SHALL move nowhere else.
REQ-018 Each transfer SHALL produce rf_we=1 with the captured addr/data exactly one cycle later; with no transfer, rf_we SHALL be 0 in that cycle.
REQ-019 A transfer with addr==0 SHALL be accepted (ready=1) but SHALL produce rf_we=0: register 0 is never written.
REQ-020 rf_waddr, rf_wdata and rf_src_b SHALL hold their last values when rf_we=0.
REQ-021 A sustained stream on either requester SHALL achieve one transfer per cycle.
REQ-022 conflict_cnt SHALL increment when a_valid and b_valid are both 1, and SHALL saturate at 16'hFFFF.
REQ-023 Requesters SHALL hold addr/data stable while valid and not ready; the block SHALL NOT check this.

Reset
REQ-024 When reset=1 at a rising edge, the block SHALL set state=A_PRIO, wait_cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, rf_src_b=0 and conflict_cnt=0.
REQ-025 A transfer in the same cycle as reset SHALL be discarded: no rf_we follows.
REQ-026 While reset=1, a_ready and b_ready SHALL be 0.

Structure
REQ-027 Shared package rf_arb_pkg SHALL hold the state encoding (A_PRIO=0, B_FORCED=1) and the default WIDTH, AddrWidth and STARVE_LIMIT constants.
REQ-028 The block SHALL have one sub-module, sat_counter16, implementing conflict_cnt.
REQ-029 The grant logic and FSM SHALL stay in rf_write_arbiter.

Verification
REQ-030 A only, a_addr=5, a_data=32'hDEADBEEF, one cycle -> a_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=32'hDEADBEEF, rf_src_b=0.
REQ-031 A and B held valid continuously, STARVE_LIMIT=4 -> A wins cycles 0-3, B is granted in cycle 4 (rf_src_b=1 in cycle 5), A resumes in cycle 5, conflict_cnt=5 after 5 cycles.
REQ-032 B only, b_addr=0, b_data=32'h1234 -> b_ready=1; rf_we stays 0 the next cycle.
REQ-033 Back-to-back A writes to addresses 1,2,3 -> rf_we=1 for three consecutive cycles with addresses 1,2,3, no bubbles.
REQ-034 Reset asserted in the cycle of a B transfer, while in B_FORCED -> next cycle rf_we=0, state A_PRIO, conflict_cnt=0.
REQ-035 Force conflict_cnt to 16'hFFFE, then hold both valid for 3 cycles -> counter reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared arbiter state encoding and default parameter values
//   Holds the A_PRIO / B_FORCED state encoding and the default data width,
//   address width and starvation limit used by rf_write_arbiter.
package rf_arb_pkg;

    typedef enum logic {
        A_PRIO   = 1'b0,
        B_FORCED = 1'b1
    } arb_state_e;

    localparam int DEF_WIDTH        = 32;
    localparam int DEF_ADDR_WIDTH   = 5;
    localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/sat_counter16.sv
// sat_counter16: 16-bit up-counter that sticks at 16'hFFFF
//   clk   : rising-edge clock
//   reset : synchronous active-high clear
//   inc   : count this cycle
//   count : current value
module sat_counter16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_count <= '0;
        else if (inc && r_count != 16'hFFFF)
            r_count <= r_count + 16'd1;
    end

    assign count = r_count;

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: two-requester register-file write-port arbiter with starvation relief
//   clk, reset                        : clock, synchronous active-high reset
//   a_valid/a_addr/a_data/a_ready     : requester A (pipeline writeback), normally preferred
//   b_valid/b_addr/b_data/b_ready     : requester B (load/MIO unit), forced after STARVE_LIMIT blocked cycles
//   rf_we/rf_waddr/rf_wdata/rf_src_b  : registered write-port drive, one cycle after the transfer
//   conflict_cnt                      : saturating count of cycles with both requesters valid
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int AddrWidth    = DEF_ADDR_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_valid,
    input  logic [AddrWidth-1:0] a_addr,
    input  logic [WIDTH-1:0]     a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [AddrWidth-1:0] b_addr,
    input  logic [WIDTH-1:0]     b_data,
    output logic                 b_ready,
    output logic                 rf_we,
    output logic [AddrWidth-1:0] rf_waddr,
    output logic [WIDTH-1:0]     rf_wdata,
    output logic                 rf_src_b,
    output logic [15:0]          conflict_cnt
);

    localparam int WaitW = $clog2(STARVE_LIMIT + 1);

    arb_state_e           r_state;
    logic [WaitW-1:0]     r_wait_cnt;
    logic                 r_we;
    logic [AddrWidth-1:0] r_waddr;
    logic [WIDTH-1:0]     r_wdata;
    logic                 r_src_b;

    logic                 w_a_xfer;
    logic                 w_b_xfer;
    logic                 w_b_blocked;
    logic                 w_starved;
    logic                 w_xfer;
    logic [AddrWidth-1:0] w_addr;
    logic [WIDTH-1:0]     w_data;

    // Readies are gated by reset so nothing is accepted in a reset cycle.
    assign a_ready     = !reset && r_state == A_PRIO && a_valid;
    assign b_ready     = !reset && b_valid && (r_state == B_FORCED || !a_valid);
    assign w_a_xfer    = a_valid && a_ready;
    assign w_b_xfer    = b_valid && b_ready;
    assign w_b_blocked = b_valid && !b_ready;
    assign w_starved   = w_b_blocked && r_wait_cnt == WaitW'(STARVE_LIMIT - 1);
    assign w_xfer      = w_a_xfer || w_b_xfer;
    assign w_addr      = w_b_xfer ? b_addr : a_addr;
    assign w_data      = w_b_xfer ? b_data : a_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= A_PRIO;
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= !w_b_blocked ? '0 :
                          (r_wait_cnt == WaitW'(STARVE_LIMIT)) ? r_wait_cnt : r_wait_cnt + 1'b1;
            r_state    <= (r_state == A_PRIO) ? (w_starved ? B_FORCED : A_PRIO) :
                          ((w_b_xfer || !b_valid) ? A_PRIO : B_FORCED);
        end
    end

    // Register 0 is hard-wired: such transfers are accepted but never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_src_b <= 1'b0;
        end else if (w_xfer && w_addr != '0) begin
            r_we    <= 1'b1;
            r_waddr <= w_addr;
            r_wdata <= w_data;
            r_src_b <= w_b_xfer;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign rf_we    = r_we;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;
    assign rf_src_b = r_src_b;

    sat_counter16 u_conflict (
        .clk   (clk),
        .reset (reset),
        .inc   (a_valid && b_valid),
        .count (conflict_cnt)
    );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed and randomized checks of rf_write_arbiter
module tb_rf_write_arbiter;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_valid, b_valid, a_ready, b_ready;
    logic [AW-1:0] a_addr, b_addr, rf_waddr;
    logic [W-1:0]  a_data, b_data, rf_wdata;
    logic          rf_we, rf_src_b;
    logic [15:0]   conflict_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.WIDTH(W), .AddrWidth(AW), .STARVE_LIMIT(SL)) dut (
        .clk          (clk),
        .reset        (reset),
        .a_valid      (a_valid),
        .a_addr       (a_addr),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .rf_src_b     (rf_src_b),
        .conflict_cnt (conflict_cnt)
    );

    task automatic set_in(input logic av, input logic [AW-1:0] aa, input logic [W-1:0] ad,
                          input logic bv, input logic [AW-1:0] ba, input logic [W-1:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(1, 7, 32'h11, 1, 9, 32'h22);
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b expected 00", {a_ready, b_ready});
        end
        @(negedge clk);
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, rf_src_b, conflict_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state: we=%b waddr=%0h wdata=%0h src=%b cnt=%0h expected all 0",
                     rf_we, rf_waddr, rf_wdata, rf_src_b, conflict_cnt);
        end
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL reset_discard: rf_we got %b expected 0", rf_we);
        end
    endtask

    task automatic test_single_a();
        do_reset();
        set_in(1, 5, 32'hDEADBEEF, 0, 0, 0);
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            errors++; $display("FAIL single_a_ready: got %b expected 10", {a_ready, b_ready});
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0);
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, rf_src_b} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b0}) begin
            errors++;
            $display("FAIL single_a_write: we=%b waddr=%0d wdata=%h src=%b expected 1/5/deadbeef/0",
                     rf_we, rf_waddr, rf_wdata, rf_src_b);
        end
        @(negedge clk);
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL single_a_hold: we=%b waddr=%0d wdata=%h expected 0/5/deadbeef",
                     rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_starve();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                checks++;
                if ({rf_we, rf_src_b} !== {1'b1, c == 5}) begin
                    errors++;
                    $display("FAIL starve_out c=%0d: we/src got %b%b expected 1%b", c, rf_we, rf_src_b, c == 5);
                end
                checks++;
                if (conflict_cnt !== 16'(c)) begin
                    errors++; $display("FAIL starve_cnt c=%0d: got %0d expected %0d", c, conflict_cnt, c);
                end
            end
            set_in(1, 5'(c + 1), 32'(c), 1, 20, 32'hB0B0);
            #1;
            checks++;
            if ({a_ready, b_ready} !== {c != 4, c == 4}) begin
                errors++;
                $display("FAIL starve_ready c=%0d: got %b%b expected %b%b", c, a_ready, b_ready, c != 4, c == 4);
            end
            @(negedge clk);
        end
        set_in(0, 0, 0, 0, 0, 0);
        checks++;
        if ({rf_we, rf_src_b, rf_waddr} !== {1'b1, 1'b0, 5'd6}) begin
            errors++;
            $display("FAIL starve_resume: we=%b src=%b waddr=%0d expected 1/0/6", rf_we, rf_src_b, rf_waddr);
        end
    endtask

    task automatic test_addr_zero();
        do_reset();
        set_in(0, 0, 0, 1, 0, 32'h1234);
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b01) begin
            errors++; $display("FAIL addr_zero_ready: got %b expected 01", {a_ready, b_ready});
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0);
        checks++;
        if ({rf_we, rf_wdata} !== {1'b0, 32'h0}) begin
            errors++; $display("FAIL addr_zero_we: we=%b wdata=%h expected 0/0", rf_we, rf_wdata);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) begin
                checks++;
                if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'(i - 1), 32'(i * 100 - 100)}) begin
                    errors++;
                    $display("FAIL b2b i=%0d: we=%b waddr=%0d wdata=%0d expected 1/%0d/%0d",
                             i, rf_we, rf_waddr, rf_wdata, i - 1, i * 100 - 100);
                end
            end
            if (i < 4) set_in(1, 5'(i), 32'(i * 100), 0, 0, 0);
            else       set_in(0, 0, 0, 0, 0, 0);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_in_forced();
        do_reset();
        set_in(1, 3, 32'h33, 1, 7, 32'h77);
        repeat (SL) @(negedge clk);
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b01) begin
            errors++; $display("FAIL forced_ready: got %b expected 01", {a_ready, b_ready});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b00) begin
            errors++; $display("FAIL forced_reset_ready: got %b expected 00", {a_ready, b_ready});
        end
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({rf_we, conflict_cnt} !== 17'h0) begin
            errors++; $display("FAIL forced_reset_out: we=%b cnt=%0d expected 0/0", rf_we, conflict_cnt);
        end
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            errors++; $display("FAIL forced_reset_state: ready got %b expected 10 (A_PRIO)", {a_ready, b_ready});
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_saturate();
        do_reset();
        set_in(1, 1, 1, 1, 2, 2);
        repeat (65534) @(negedge clk);
        checks++;
        if (conflict_cnt !== 16'hFFFE) begin
            errors++; $display("FAIL sat_fffe: got %h expected fffe", conflict_cnt);
        end
        @(negedge clk);
        checks++;
        if (conflict_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_ffff: got %h expected ffff", conflict_cnt);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (conflict_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold: got %h expected ffff", conflict_cnt);
        end
        set_in(0, 0, 0, 0, 0, 0);
    endtask

    // Reference model: B is forced once it has been refused SL cycles in a row;
    // the forced condition lasts one grant opportunity.
    task automatic test_random();
        int          streak, cnt;
        logic        ewe, esrc, forced, ga, gb;
        logic [AW-1:0] eaddr;
        logic [W-1:0]  edata;
        do_reset();
        streak = 0; cnt = 0; ewe = 0; esrc = 0; eaddr = 0; edata = 0;
        for (int i = 0; i < 600; i++) begin
            checks++;
            if ({rf_we, rf_waddr, rf_wdata, rf_src_b} !== {ewe, eaddr, edata, esrc}) begin
                errors++;
                $display("FAIL rand_out i=%0d: we=%b waddr=%0d wdata=%h src=%b expected %b/%0d/%h/%b",
                         i, rf_we, rf_waddr, rf_wdata, rf_src_b, ewe, eaddr, edata, esrc);
            end
            checks++;
            if (conflict_cnt !== 16'(cnt)) begin
                errors++; $display("FAIL rand_cnt i=%0d: got %0d expected %0d", i, conflict_cnt, cnt);
            end
            reset = ($urandom_range(0, 49) == 0);
            set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
                   $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom);
            #1;
            forced = streak >= SL;
            gb = !reset && b_valid && (forced || !a_valid);
            ga = !reset && a_valid && !forced;
            checks++;
            if ({a_ready, b_ready} !== {ga, gb}) begin
                errors++;
                $display("FAIL rand_ready i=%0d: got %b%b expected %b%b", i, a_ready, b_ready, ga, gb);
            end
            if (reset) begin
                streak = 0; cnt = 0; ewe = 0; esrc = 0; eaddr = 0; edata = 0;
            end else begin
                streak = (b_valid && !gb) ? streak + 1 : 0;
                if (a_valid && b_valid && cnt < 65535) cnt++;
                ewe = (ga && a_addr != 0) || (gb && b_addr != 0);
                if (ewe) begin
                    eaddr = gb ? b_addr : a_addr;
                    edata = gb ? b_data : a_data;
                    esrc  = gb;
                end
            end
            @(negedge clk);
        end
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_starve();
        test_addr_zero();
        test_back_to_back();
        test_reset_in_forced();
        test_random();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
